matrix_input_loader: RTL and testbench

Input-side front end for the matrix multiplier demo. It debounces the load push-button and captures two packed 2x2 operand bytes, matrixA and then matrixB, from the 8-bit switch bus. It then presents both operands to the multiplier under a valid/ack handshake. It is the writer counterpart of the matrixC-to-7-segment display path: the operand byte packing is identical, with element1 in [1:0] through element4 in [7:6], each element 2 bits.

---
 rtl/matrix_input_loader_if.sv | 21 ++
 rtl/matrix_input_loader.sv | 106 ++++++++++
 tb/tb_matrix_input_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/matrix_input_loader_if.sv
// Operand/handshake bundle between the switch-side loader and the matrix multiplier.
interface matrix_input_loader_if;
    logic [7:0] data_in;
    logic       load_btn;
    logic       clear;
    logic       ack;
    logic [7:0] matrixA;
    logic [7:0] matrixB;
    logic       matrices_valid;
    logic       expect_b;

    modport master (
        output data_in, load_btn, clear, ack,
        input  matrixA, matrixB, matrices_valid, expect_b
    );

    modport slave (
        input  data_in, load_btn, clear, ack,
        output matrixA, matrixB, matrices_valid, expect_b
    );
endinterface

// File: rtl/matrix_input_loader.sv
// Debounced push-button loader: captures matrixA then matrixB from the switches
// and offers both operands to the multiplier under a valid/ack handshake.
module matrix_input_loader #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_input_loader_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_B, VALID} state_e;

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             press;

    state_e           state_q;
    logic [7:0]       mat_a_q, mat_b_q;
    logic             valid_q, expect_b_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        cnt_d   = '0;
        deb_d   = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= bus.load_btn;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // clear outranks ack, which outranks a press landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mat_a_q    <= 8'h00;
            mat_b_q    <= 8'h00;
            valid_q    <= 1'b0;
            expect_b_q <= 1'b0;
        end else if (bus.clear) begin
            state_q    <= IDLE;
            mat_a_q    <= 8'h00;
            mat_b_q    <= 8'h00;
            valid_q    <= 1'b0;
            expect_b_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        mat_a_q    <= bus.data_in;
                        state_q    <= WAIT_B;
                        expect_b_q <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (press) begin
                        mat_b_q    <= bus.data_in;
                        state_q    <= VALID;
                        expect_b_q <= 1'b0;
                        valid_q    <= 1'b1;
                    end
                end
                VALID: begin
                    // Operands are kept after ack so the display still shows them.
                    if (bus.ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    valid_q    <= 1'b0;
                    expect_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.matrixA        = mat_a_q;
    assign bus.matrixB        = mat_b_q;
    assign bus.matrices_valid = valid_q;
    assign bus.expect_b       = expect_b_q;
endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader: one instance at DEBOUNCE_CYCLES=4, one at 1.
module tb_matrix_input_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    matrix_input_loader_if if4 ();
    matrix_input_loader_if if1 ();

    matrix_input_loader #(.DEBOUNCE_CYCLES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    matrix_input_loader #(.DEBOUNCE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs set afterwards apply to the next edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the button; returns just after edge 6 (capture happens on edge 7).
    task automatic press_head(input logic [7:0] d);
        if4.data_in  = d;
        if4.load_btn = 1'b1;
        tick(6);
    endtask

    // Finish an 8-cycle hold and wait out the debounced release.
    task automatic press_tail();
        tick(1);
        if4.load_btn = 1'b0;
        tick(8);
    endtask

    task automatic full_press(input logic [7:0] d);
        press_head(d);
        tick(1);
        press_tail();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checks++; if (if4.matrixA !== 8'h00) begin errors++; $display("FAIL reset_matrixA got=%h exp=00", if4.matrixA); end
        checks++; if (if4.matrixB !== 8'h00) begin errors++; $display("FAIL reset_matrixB got=%h exp=00", if4.matrixB); end
        checks++; if (if4.matrices_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if4.matrices_valid); end
        checks++; if (if4.expect_b !== 1'b0) begin errors++; $display("FAIL reset_expect_b got=%b exp=0", if4.expect_b); end
    endtask

    task automatic test_clean_load();
        press_head(8'h1B);
        checks++; if (if4.matrixA !== 8'h00) begin errors++; $display("FAIL load_a_early got=%h exp=00", if4.matrixA); end
        tick(1);
        checks++; if (if4.matrixA !== 8'h1B) begin errors++; $display("FAIL load_a_edge7 got=%h exp=1b", if4.matrixA); end
        checks++; if (if4.expect_b !== 1'b1) begin errors++; $display("FAIL load_a_expect_b got=%b exp=1", if4.expect_b); end
        press_tail();
        press_head(8'hE4);
        checks++; if (if4.matrices_valid !== 1'b0) begin errors++; $display("FAIL load_b_early_valid got=%b exp=0", if4.matrices_valid); end
        tick(1);
        checks++; if (if4.matrixB !== 8'hE4) begin errors++; $display("FAIL load_b got=%h exp=e4", if4.matrixB); end
        checks++; if (if4.matrices_valid !== 1'b1) begin errors++; $display("FAIL load_b_valid got=%b exp=1", if4.matrices_valid); end
        checks++; if (if4.expect_b !== 1'b0) begin errors++; $display("FAIL load_b_expect_b got=%b exp=0", if4.expect_b); end
        checks++; if (if4.matrixA !== 8'h1B) begin errors++; $display("FAIL load_b_keep_a got=%h exp=1b", if4.matrixA); end
        press_tail();
    endtask

    task automatic test_handshake();
        full_press(8'hFF);
        checks++; if (if4.matrixA !== 8'h1B) begin errors++; $display("FAIL hs_ignore_a got=%h exp=1b", if4.matrixA); end
        checks++; if (if4.matrixB !== 8'hE4) begin errors++; $display("FAIL hs_ignore_b got=%h exp=e4", if4.matrixB); end
        checks++; if (if4.matrices_valid !== 1'b1) begin errors++; $display("FAIL hs_still_valid got=%b exp=1", if4.matrices_valid); end
        if4.ack = 1'b1;
        tick(1);
        if4.ack = 1'b0;
        checks++; if (if4.matrices_valid !== 1'b0) begin errors++; $display("FAIL hs_ack_drop got=%b exp=0", if4.matrices_valid); end
        checks++; if (if4.matrixA !== 8'h1B || if4.matrixB !== 8'hE4) begin errors++; $display("FAIL hs_retain got=%h/%h exp=1b/e4", if4.matrixA, if4.matrixB); end
        full_press(8'h5A);
        checks++; if (if4.matrixA !== 8'h5A) begin errors++; $display("FAIL hs_reload_a got=%h exp=5a", if4.matrixA); end
        checks++; if (if4.expect_b !== 1'b1) begin errors++; $display("FAIL hs_reload_expect_b got=%b exp=1", if4.expect_b); end
    endtask

    task automatic test_simultaneous();
        full_press(8'h33);
        checks++; if (if4.matrixB !== 8'h33 || if4.matrices_valid !== 1'b1) begin errors++; $display("FAIL sim_setup got=%h/%b exp=33/1", if4.matrixB, if4.matrices_valid); end
        press_head(8'hCC);
        if4.ack = 1'b1;
        tick(1);
        if4.ack = 1'b0;
        checks++; if (if4.matrices_valid !== 1'b0 || if4.expect_b !== 1'b0) begin errors++; $display("FAIL sim_ack_idle got=%b/%b exp=0/0", if4.matrices_valid, if4.expect_b); end
        press_tail();
        checks++; if (if4.matrixA !== 8'h5A || if4.matrixB !== 8'h33 || if4.expect_b !== 1'b0) begin errors++; $display("FAIL sim_ack_no_capture got=%h/%h/%b exp=5a/33/0", if4.matrixA, if4.matrixB, if4.expect_b); end
        full_press(8'h11);
        press_head(8'h22);
        if4.clear = 1'b1;
        tick(1);
        if4.clear = 1'b0;
        checks++; if (if4.matrixA !== 8'h00 || if4.matrixB !== 8'h00) begin errors++; $display("FAIL sim_clear_zero got=%h/%h exp=00/00", if4.matrixA, if4.matrixB); end
        checks++; if (if4.expect_b !== 1'b0 || if4.matrices_valid !== 1'b0) begin errors++; $display("FAIL sim_clear_idle got=%b/%b exp=0/0", if4.expect_b, if4.matrices_valid); end
        press_tail();
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b11101;
        if4.data_in = 8'hA7;
        for (int i = 0; i < 5; i++) begin
            if4.load_btn = pat[i];
            tick(1);
        end
        if4.load_btn = 1'b0;
        tick(10);
        checks++; if (if4.matrixA !== 8'h00) begin errors++; $display("FAIL bounce_matrixA got=%h exp=00", if4.matrixA); end
        checks++; if (if4.expect_b !== 1'b0) begin errors++; $display("FAIL bounce_expect_b got=%b exp=0", if4.expect_b); end
    endtask

    task automatic test_reset_midop();
        full_press(8'h77);
        checks++; if (if4.expect_b !== 1'b1) begin errors++; $display("FAIL rst_setup got=%b exp=1", if4.expect_b); end
        if4.data_in  = 8'h99;
        if4.load_btn = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checks++; if (if4.matrixA !== 8'h00 || if4.matrixB !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h/%h exp=00/00", if4.matrixA, if4.matrixB); end
        checks++; if (if4.expect_b !== 1'b0 || if4.matrices_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", if4.expect_b, if4.matrices_valid); end
        tick(6);
        checks++; if (if4.matrixA !== 8'h00) begin errors++; $display("FAIL rst_repress_early got=%h exp=00", if4.matrixA); end
        tick(1);
        checks++; if (if4.matrixA !== 8'h99 || if4.expect_b !== 1'b1) begin errors++; $display("FAIL rst_repress got=%h/%b exp=99/1", if4.matrixA, if4.expect_b); end
        press_tail();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            if1.load_btn = ((i % 4) < 2);
            if1.data_in  = (i < 4) ? 8'hA5 : 8'h3C;
            tick(1);
            if (i == 2) begin
                checks++; if (if1.matrixA !== 8'h00) begin errors++; $display("FAIL b2b_early got=%h exp=00", if1.matrixA); end
            end
            if (i == 3) begin
                checks++; if (if1.matrixA !== 8'hA5 || if1.expect_b !== 1'b1) begin errors++; $display("FAIL b2b_edge4 got=%h/%b exp=a5/1", if1.matrixA, if1.expect_b); end
            end
        end
        checks++; if (if1.matrixB !== 8'h3C || if1.matrices_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=3c/1", if1.matrixB, if1.matrices_valid); end
        checks++; if (if1.matrixA !== 8'hA5) begin errors++; $display("FAIL b2b_keep_a got=%h exp=a5", if1.matrixA); end
        if1.load_btn = 1'b0;
        tick(4);
    endtask

    initial begin
        if4.data_in = 8'h00; if4.load_btn = 1'b0; if4.clear = 1'b0; if4.ack = 1'b0;
        if1.data_in = 8'h00; if1.load_btn = 1'b0; if1.clear = 1'b0; if1.ack = 1'b0;
        tick(1);
        test_reset();
        test_clean_load();
        test_handshake();
        test_simultaneous();
        test_bounce();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
